prbs_gen: RTL and testbench
===========================

# prbs_gen

Parametrised serial test-data source feeding the HDB3 encoder and bench checkers.
- Generalises the fixed 4-bit LFSR source to any PRBS length and tap set, and adds a seed load.
- Adds HDB3 stress pattern modes, a valid/ready output handshake and a sequence-start marker.
- Sits at the head of the transmit path: one bit per accepted beat into the encoder.

## Interface
Parameters:
- WIDTH, 7 — LFSR length (2..32).
- TAPS, 7'h60 — feedback mask; bit i set means lfsr[i] is XORed into the feedback (7'h60 gives x^7+x^6+1).
- SEED, 1 — reset and fallback seed. Must be nonzero.
- PAT_LEN, 16 — length of the fixed pattern in mode 3.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — asynchronous, active-high reset.
- en  in  1  — run request.
- mode  in  2  — pattern select: 0 PRBS, 1 all-zeros, 2 alternating 1010…, 3 fixed pattern.
- seed_load  in  1  — load `seed` into the LFSR (honoured in IDLE only).
- seed  in  WIDTH  — seed value.
- pattern  in  PAT_LEN  — fixed pattern, emitted MSB first.
- data_ready  in  1  — downstream accepts the current bit.
- data_out  out  1  — current bit.
- data_valid  out  1  — `data_out` is valid.
- period_mark  out  1  — high with the first bit of each PRBS period (mode 0 only).

## Operation
- A beat is accepted when data_valid && data_ready. All internal advance happens only on accepted beats, or when the output register is empty.
- **PRBS step** (Fibonacci): data_out = lfsr[WIDTH-1]; lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- **Zero-seed guard:** a seed_load of all-zeros loads SEED instead; the LFSR can never hold zero.
- **Modes:** `mode` is latched on the IDLE→RUN transition. Changes while running are ignored until the next IDLE.
  - Mode 1 emits constant 0 (exercises V/B substitution).
  - Mode 2 emits 1,0,1,0…, starting with 1.
  - Mode 3 emits pattern[PAT_LEN-1]…pattern[0], then repeats. A $clog2(PAT_LEN) index wraps at PAT_LEN-1 → 0.
  - The LFSR holds its value in modes 1–3.
- **Bit counter:** counts accepted bits in mode 0 and wraps at 2^WIDTH-2. period_mark = (count == 0) && data_valid. The count is cleared on entry to RUN, so the first bit after start is marked.
- **State machine:**
  - IDLE: data_valid = 0.
    - seed_load → load; stay in IDLE.
    - en → RUN.
    - seed_load and en in the same cycle: load wins, start is deferred one cycle.
  - RUN: produce and advance on acceptance.
    - en low with no pending beat, or with a beat accepted this cycle → IDLE.
    - en low with a pending unaccepted beat → DRAIN.
  - DRAIN: hold data_out/data_valid; no new bits. On acceptance → IDLE.
    - en re-asserted during DRAIN is ignored until IDLE is reached.

## Timing
- All outputs are registered.
- Reset values: data_out = 0, data_valid = 0, period_mark = 0, state = IDLE, lfsr = SEED, counters = 0.
- Start latency: en sampled high in IDLE at edge N → data_valid = 1 after edge N, carrying the first bit (lfsr MSB / pattern MSB / 1 / 0).
- Throughput: one bit per cycle while data_ready is held high.
- Backpressure: data_ready low → data_out, data_valid and all state hold unchanged.
- Reset mid-operation: immediate return to reset values. Any pending beat is dropped.

## Configuration
- `PRBS_ERR_INJ_EN` defined:
  - Adds input `err_inject` (1 bit).
  - A pulse arms a one-shot flag. The next accepted bit, in any mode, is emitted inverted; the flag then clears.
  - The LFSR, counters and period_mark are unaffected.
  - Pulses arriving while armed are absorbed.
  - The flag clears on reset and on entering IDLE.
- Not defined: no `err_inject` port and no inversion logic. Output is bit-exact to the ideal sequence.

## Structure
- Package `prbs_pkg`:
  - Mode encodings MODE_PRBS, MODE_ZERO, MODE_ALT, MODE_PAT.
  - State encodings IDLE, RUN, DRAIN.
  - Standard tap constants TAPS_PRBS7 = 7'h60, TAPS_PRBS9 = 9'h110, TAPS_PRBS15 = 15'h6000, TAPS_PRBS23 = 23'h420000.
- Sub-module `lfsr_core` (parameters WIDTH, TAPS, SEED; ports load, load_val, step, state).
  - Contains the Fibonacci stepper and the zero-seed guard.
  - Reused by the receive-side PRBS checker.

## Test plan
- PRBS7, default seed, data_ready = 1, en = 1: first 7 bits 0,0,0,0,0,0,1; sequence repeats after exactly 127 bits; period_mark high on bits 0, 127 and 254.
- seed_load with seed = 0 in IDLE, then en: behaves exactly as seed = SEED. seed_load = 7'h40: first bit 1.
- Mode 3, PAT_LEN = 16, pattern = 16'h8001: output 1, then fourteen 0s, then 1, repeating; the mode input toggled mid-run has no effect.
- data_ready low for 5 cycles mid-stream: data_out held constant; the following accepted bits continue the sequence with no gap or duplicate.
- en dropped while data_ready = 0: state DRAIN, data_valid stays 1 until accepted, then 0 (IDLE); rst asserted in DRAIN → all outputs 0 on the next sample.
- With `PRBS_ERR_INJ_EN`: err_inject pulse during PRBS7 → exactly one accepted bit inverted versus the reference model; the next period_mark is at the unchanged position.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg - shared definitions for the PRBS test-data source and the
// receive-side checker built on the same LFSR core.
//   mode_e  : pattern select encodings driven on prbs_gen.mode
//   state_e : sequencer states (IDLE, RUN, DRAIN)
//   TAPS_*  : feedback masks for the standard ITU PRBS polynomials
package prbs_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS = 2'd0,
        MODE_ZERO = 2'd1,
        MODE_ALT  = 2'd2,
        MODE_PAT  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bit i set means lfsr[i] feeds the XOR; e.g. x^7 + x^6 + 1 -> bits 6 and 5.
    localparam logic [6:0]  TAPS_PRBS7  = 7'h60;
    localparam logic [8:0]  TAPS_PRBS9  = 9'h110;
    localparam logic [14:0] TAPS_PRBS15 = 15'h6000;
    localparam logic [22:0] TAPS_PRBS23 = 23'h420000;

endpackage

// File: rtl/prbs_gen_lfsr_core.sv
// lfsr_core - Fibonacci LFSR stepper with seed load and zero-seed guard.
// The output bit of a step is state[WIDTH-1]; the register then shifts left
// and the XOR of the tapped bits enters at bit 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (state <= SEED)
//   load      : load load_val (an all-zero load_val loads SEED instead)
//   load_val  : seed value
//   step      : advance one position (load has priority)
//   state     : current LFSR contents, never zero
module lfsr_core
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_PRBS7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic feedback;

    assign feedback = ^(state & TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            // The all-zero state is a fixed point of the XOR feedback, so it
            // must never be loaded.
            state <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state <= {state[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/prbs_gen.sv
// prbs_gen - parametrised serial test-data source for the HDB3 transmit path.
// Emits one bit per accepted beat (data_valid && data_ready): a PRBS, all
// zeros, alternating 1010..., or a fixed pattern sent MSB first.
// Optional build macro: PRBS_ERR_INJ_EN adds err_inject, a one-shot request
// to invert the next produced bit.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : run request
//   mode        : 0 PRBS, 1 zeros, 2 alternating, 3 pattern (latched at start)
//   seed_load   : load seed into the LFSR (IDLE only, wins over en)
//   seed        : seed value (zero maps to SEED)
//   pattern     : fixed pattern for mode 3, emitted MSB first
//   data_ready  : downstream accepts the current bit
//   err_inject  : (PRBS_ERR_INJ_EN only) arm a one-bit inversion
//   data_out    : current bit
//   data_valid  : data_out is valid
//   period_mark : first bit of each PRBS period (mode 0 only)
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH   = 7,
    parameter logic [WIDTH-1:0] TAPS    = TAPS_PRBS7,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
    parameter int unsigned      PAT_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               data_ready,
`ifdef PRBS_ERR_INJ_EN
    input  logic               err_inject,
`endif
    output logic               data_out,
    output logic               data_valid,
    output logic               period_mark
);

    localparam int unsigned      IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] PAT_LAST = IDX_W'(PAT_LEN - 1);
    // The bit counter runs 0 .. 2^WIDTH-2, one value per bit of a PRBS period.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    state_e           state;
    mode_e            mode_q;
    logic [WIDTH-1:0] bit_cnt;
    logic [IDX_W-1:0] pat_idx;   // index of the next pattern bit to emit
    logic             alt_bit;   // next alternating bit to emit

    logic             lfsr_msb;
    logic [WIDTH-2:0] lfsr_low_unused;

    logic             accept;
    logic             start;
    logic             advance;
    logic             to_idle;
    logic             produce;
    logic             flip;
    mode_e            mode_sel;
    logic [IDX_W-1:0] idx_cur;
    logic [IDX_W-1:0] idx_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             alt_cur;
    logic             next_bit;

    assign accept  = data_valid & data_ready;
    // Start fills the empty output register; seed_load defers it one cycle.
    assign start   = (state == IDLE) & en & ~seed_load;
    assign advance = (state == RUN) & accept & en;
    assign to_idle = accept & (((state == RUN) & ~en) | (state == DRAIN));
    assign produce = start | advance;

    // On the start cycle the live mode input and fresh counters apply, since
    // the latched copies only update at that same edge.
    assign mode_sel = start ? mode_e'(mode) : mode_q;
    assign idx_cur  = start ? '0 : pat_idx;
    assign idx_nxt  = (idx_cur == PAT_LAST) ? '0 : idx_cur + 1'b1;
    assign cnt_nxt  = start ? '0 : ((bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1);
    assign alt_cur  = start | alt_bit;

    // The LFSR always sits one step ahead of data_out: its MSB is the next
    // PRBS bit to be produced.
    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == IDLE) & seed_load),
        .load_val (seed),
        .step     (produce & (mode_sel == MODE_PRBS)),
        .state    ({lfsr_msb, lfsr_low_unused})
    );

    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational; a path that leaves next_bit unassigned would infer a latch.
        next_bit = 1'b0;
        case (mode_sel)
            MODE_PRBS: next_bit = lfsr_msb;
            MODE_ZERO: next_bit = 1'b0;
            MODE_ALT:  next_bit = alt_cur;
            MODE_PAT:  next_bit = pattern[PAT_LAST - idx_cur];
            default:   next_bit = 1'b0;
        endcase
    end

`ifdef PRBS_ERR_INJ_EN
    logic err_armed;

    // One-shot: armed by a pulse, consumed by the next produced bit. Pulses
    // while armed are absorbed; returning to IDLE disarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_armed <= 1'b0;
        end else if (to_idle) begin
            err_armed <= 1'b0;
        end else if (produce && err_armed) begin
            err_armed <= 1'b0;
        end else if (err_inject) begin
            err_armed <= 1'b1;
        end
    end

    assign flip = err_armed;
`else
    assign flip = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all state
    // updates from the same edge see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_PRBS;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            period_mark <= 1'b0;
            bit_cnt     <= '0;
            pat_idx     <= '0;
            alt_bit     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (to_idle)  state <= IDLE;
                    else if (!en) state <= DRAIN;
                end
                DRAIN: begin
                    // en is ignored here; the pending beat must drain first.
                    if (accept) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (start) mode_q <= mode_e'(mode);

            if (produce) begin
                data_out    <= next_bit ^ flip;
                data_valid  <= 1'b1;
                period_mark <= (mode_sel == MODE_PRBS) && (cnt_nxt == '0);
                if (mode_sel == MODE_PRBS) bit_cnt <= cnt_nxt;
                pat_idx     <= idx_nxt;
                alt_bit     <= ~alt_cur;
            end else if (to_idle) begin
                data_valid  <= 1'b0;
                period_mark <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen.sv
// tb_prbs_gen - self-checking bench for prbs_gen (PRBS7, PAT_LEN 16).
// The reference model describes the output as a bit sequence: the PRBS is the
// linear recurrence s[k] = XOR of s[k-1-i] over tap bits i, seeded from the
// seed MSB first; other modes are functions of the bit index within a run.
// Define PRBS_ERR_INJ_EN to also cover the error-injection option.
module tb_prbs_gen;

    localparam int           W       = 7;
    localparam logic [W-1:0] TAPS    = 7'h60;
    localparam logic [W-1:0] SEED    = 7'd1;
    localparam int           PAT_LEN = 16;
    localparam int           PERIOD  = (1 << W) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;

    logic               clk        = 1'b0;
    logic               rst        = 1'b0;
    logic               en         = 1'b0;
    logic [1:0]         mode       = 2'd0;
    logic               seed_load  = 1'b0;
    logic [W-1:0]       seed       = '0;
    logic [PAT_LEN-1:0] pattern    = '0;
    logic               data_ready = 1'b0;
`ifdef PRBS_ERR_INJ_EN
    logic               err_inject = 1'b0;
`endif
    logic               data_out;
    logic               data_valid;
    logic               period_mark;

    always #5 clk = ~clk;

    prbs_gen #(
        .WIDTH   (W),
        .TAPS    (TAPS),
        .SEED    (SEED),
        .PAT_LEN (PAT_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .seed_load   (seed_load),
        .seed        (seed),
        .pattern     (pattern),
        .data_ready  (data_ready),
`ifdef PRBS_ERR_INJ_EN
        .err_inject  (err_inject),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .period_mark (period_mark)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         m_phase;
    logic       m_valid, m_out, m_mark, m_ideal, m_armed;
    logic [1:0] m_mode;
    int         run_idx;
    logic       seq[$];
    int         seq_pos;

    function automatic void seq_init(input logic [W-1:0] s);
        seq.delete();
        for (int k = 0; k < W; k++) seq.push_back(s[W-1-k]);
        seq_pos = 0;
    endfunction

    function automatic logic prbs_bit(input int n);
        while (seq.size() <= n) begin
            int   k;
            logic b;
            k = seq.size();
            b = 1'b0;
            for (int i = 0; i < W; i++) if (TAPS[i]) b ^= seq[k-1-i];
            seq.push_back(b);
        end
        return seq[n];
    endfunction

    function automatic logic [6:0] model_bits(input int base);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[6-i] = prbs_bit(base + i);
        return r;
    endfunction

    function automatic void model_reset();
        m_phase = PH_IDLE;
        m_valid = 1'b0;
        m_out   = 1'b0;
        m_mark  = 1'b0;
        m_ideal = 1'b0;
        m_armed = 1'b0;
        m_mode  = 2'd0;
        run_idx = 0;
        seq_init(SEED);
    endfunction

    function automatic void model_step();
        logic acc, go_idle, produce;
        acc     = m_valid && data_ready;
        go_idle = 1'b0;
        produce = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (seed_load) seq_init((seed == '0) ? SEED : seed);
                else if (en) begin
                    m_phase = PH_RUN;
                    m_mode  = mode;
                    run_idx = 0;
                    produce = 1'b1;
                end
            end
            PH_RUN: begin
                if (acc) begin
                    if (en) produce = 1'b1;
                    else    go_idle = 1'b1;
                end else if (!en) begin
                    m_phase = PH_DRAIN;
                end
            end
            default: if (acc) go_idle = 1'b1;
        endcase

        if (go_idle) begin
            m_phase = PH_IDLE;
            m_valid = 1'b0;
            m_mark  = 1'b0;
        end else if (produce) begin
            case (m_mode)
                2'd0: begin m_ideal = prbs_bit(seq_pos); seq_pos++; end
                2'd1: m_ideal = 1'b0;
                2'd2: m_ideal = (run_idx % 2 == 0);
                default: m_ideal = pattern[PAT_LEN - 1 - (run_idx % PAT_LEN)];
            endcase
            m_out   = m_ideal;
            m_mark  = (m_mode == 2'd0) && (run_idx % PERIOD == 0);
            m_valid = 1'b1;
            run_idx++;
        end

`ifdef PRBS_ERR_INJ_EN
        if (go_idle) m_armed = 1'b0;
        else if (produce && m_armed) begin
            m_out   = ~m_out;
            m_armed = 1'b0;
        end else if (err_inject) m_armed = 1'b1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // One compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("valid", data_valid, m_valid);
            if (m_valid) begin
                check("data", data_out, m_out);
                check("mark", period_mark, m_mark);
            end else begin
                check("mark_idle", period_mark, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic cap [0:259];
    logic mk  [0:259];

    initial begin
        logic [6:0] head;
        int         bad;
        int         ones;
        int         marks;
        logic       held;
`ifdef PRBS_ERR_INJ_EN
        int         inj_diffs;
`endif

        rst        = 1'b1;
        data_ready = 1'b1;
        repeat (3) tick();
        cmp_on = 1'b1;
        check("rst_valid", data_valid, 1'b0);
        check("rst_out", data_out, 1'b0);
        check("rst_mark", period_mark, 1'b0);

        // Pin the model itself to hand-derived PRBS7 values.
        check("model_head", model_bits(0), 7'b0000001);
        check("model_wrap", model_bits(PERIOD), 7'b0000001);

        // PRBS7 from the default seed, ready held high.
        rst  = 1'b0;
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            cap[i] = data_out;
            mk[i]  = period_mark;
        end
        for (int i = 0; i < 7; i++) head[6-i] = cap[i];
        check("prbs7_head", head, 7'b0000001);
        bad  = 0;
        ones = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (cap[i] !== cap[i+PERIOD]) bad++;
            if (cap[i] === 1'b1) ones++;
        end
        check("period_127", bad, 0);
        check("ones_per_period", ones, 64);
        marks = 0;
        for (int i = 0; i < 260; i++) if (mk[i] === 1'b1) marks++;
        check("mark_count", marks, 3);
        check("mark_0_127_254", {mk[0], mk[127], mk[254], mk[1], mk[126]}, 5'b11100);

        // Zero seed load behaves as SEED.
        en = 1'b0;
        tick();
        check("stop_idle", data_valid, 1'b0);
        seed      = '0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        en        = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            head[6-i] = data_out;
        end
        check("zero_seed_head", head, 7'b0000001);

        // seed_load with en: load wins, start one cycle later, first bit 1.
        en = 1'b0;
        tick();
        seed      = 7'h40;
        seed_load = 1'b1;
        en        = 1'b1;
        tick();
        check("load_defers_start", data_valid, 1'b0);
        seed_load = 1'b0;
        tick();
        check("seed40_first", {data_valid, data_out}, 2'b11);

        // Fixed pattern 16'h8001; mode input scrambled mid-run.
        en = 1'b0;
        tick();
        mode    = 2'd3;
        pattern = 16'h8001;
        en      = 1'b1;
        bad     = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_out !== ((i % 16 == 0) || (i % 16 == 15))) bad++;
            mode = 2'($urandom_range(0, 3));
        end
        check("pattern_8001", bad, 0);

        // Backpressure mid-stream in PRBS mode.
        en = 1'b0;
        tick();
        mode = 2'd0;
        en   = 1'b1;
        repeat (10) tick();
        data_ready = 1'b0;
        tick();
        held = data_out;
        bad  = 0;
        repeat (5) begin
            tick();
            if (data_out !== held || data_valid !== 1'b1) bad++;
        end
        check("backpressure_hold", bad, 0);
        data_ready = 1'b1;
        repeat (20) tick();

        // en dropped while stalled: DRAIN holds the beat, en re-assert ignored.
        data_ready = 1'b0;
        en         = 1'b0;
        tick();
        check("drain_valid", data_valid, 1'b1);
        held = data_out;
        en   = 1'b1;
        repeat (3) tick();
        check("drain_hold", {data_valid, data_out}, {1'b1, held});
        data_ready = 1'b1;
        en         = 1'b0;
        tick();
        check("drain_done", data_valid, 1'b0);

        // Reset while in DRAIN clears outputs immediately.
        en = 1'b1;
        repeat (4) tick();
        data_ready = 1'b0;
        en         = 1'b0;
        tick();
        check("drain2_valid", data_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_in_drain", {data_out, data_valid, period_mark}, 3'b000);
        tick();
        rst = 1'b0;

`ifdef PRBS_ERR_INJ_EN
        // One pulse inverts exactly one produced bit; marks stay in place.
        mode       = 2'd0;
        data_ready = 1'b1;
        en         = 1'b1;
        repeat (5) tick();
        inj_diffs  = 0;
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        repeat (30) begin
            tick();
            if (data_valid && data_out !== m_ideal) inj_diffs++;
        end
        check("inject_one_bit", inj_diffs, 1);
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            data_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            mode      = 2'($urandom_range(0, 3));
            seed_load = ($urandom_range(0, 40) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 60) == 0) pattern = PAT_LEN'($urandom);
`ifdef PRBS_ERR_INJ_EN
            err_inject = ($urandom_range(0, 30) == 0);
`endif
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
